// File: rtl/shifter_pkg.sv
// Shared encodings for the multi-cycle shifter: operation modes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational shift of 0..STEP positions in any of the four modes.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] data_o
);

  logic [2*WIDTH-1:0] rot;

  // Rotation via a doubled operand: the low half of the shifted pair is the rotate.
  assign rot = {data_i, data_i} >> amt_i;

  always_comb begin
    data_o = data_i;
    case (mode_i)
      MODE_SLL: data_o = data_i << amt_i;
      MODE_SRL: data_o = data_i >> amt_i;
      MODE_SRA: data_o = $signed(data_i) >>> amt_i;
      MODE_ROR: data_o = rot[WIDTH-1:0];
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shifter_multicycle.sv
// Iterative shifter: up to STEP positions per cycle, result registered in DONE.
module shifter_multicycle
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  // One extra bit so STEP == WIDTH is representable in the step amount.
  localparam int AMT_W = SHAMT_W + 1;
  localparam logic [AMT_W-1:0] STEP_L = AMT_W'(STEP);

  state_e             state_q;
  mode_e              mode_q;
  logic [WIDTH-1:0]   work_q, work_d, result_q;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               busy_q, done_q;
  logic [AMT_W-1:0]   cnt_ext, step_amt;

  always_comb begin
    cnt_ext  = {1'b0, count_q};
    step_amt = (cnt_ext > STEP_L) ? STEP_L : cnt_ext;
    count_d  = count_q - step_amt[SHAMT_W-1:0];
  end

  shift_step #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_step (
    .data_i (work_q),
    .amt_i  (step_amt),
    .mode_i (mode_q),
    .data_o (work_d)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SLL;
      work_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q  <= data_in;
            count_q <= shamt;
            mode_q  <= mode_e'(mode);
            busy_q  <= 1'b1;
            state_q <= (shamt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          work_q  <= work_d;
          count_q <= count_d;
          if (count_d == '0) state_q <= DONE;
        end
        DONE: begin
          result_q <= work_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shifter_multicycle.sv
// Bench for shifter_multicycle: STEP=1 and STEP=4 instances against a reference model.
module tb_shifter_multicycle;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  shamt = '0;
  logic [31:0] data_in = '0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  shifter_multicycle #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode), .shamt(shamt),
    .data_in(data_in), .busy(busy1), .done(done1), .result(result1)
  );

  shifter_multicycle #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .mode(mode), .shamt(shamt),
    .data_in(data_in), .busy(busy4), .done(done4), .result(result4)
  );

  typedef struct {
    logic [1:0]  m;
    int          sh;
    logic [31:0] d;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whole shift computed at once from the mode definitions.
  function automatic logic [31:0] ref_shift(logic [1:0] m, int sh, logic [31:0] d);
    logic [31:0] ones = 32'hFFFF_FFFF;
    if (sh == 0) return d;
    case (m)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return (d >> sh) | (d[31] ? ~(ones >> sh) : 32'h0);
      default: return (d >> sh) | (d << (32 - sh));
    endcase
  endfunction

  function automatic int ref_lat(int sh, int step);
    return (sh + step - 1) / step + 1;
  endfunction

  // Issue one request on the selected instance; inputs are scrambled after acceptance.
  task automatic do_op(input bit use4, input logic [1:0] m, input int sh, input logic [31:0] d,
                       output int lat, output int bcyc, output logic [31:0] res);
    mode = m; shamt = 5'(sh); data_in = d;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    mode = 2'($urandom); shamt = 5'($urandom); data_in = $urandom;
    lat = -1; bcyc = 0; res = 'x;
    for (int i = 1; i <= 100; i++) begin
      if (use4 ? busy4 : busy1) bcyc++;
      @(posedge clk); #1;
      if (use4 ? done4 : done1) begin
        lat = i;
        res = use4 ? result4 : result1;
        break;
      end
    end
  endtask

  initial begin
    vec_t vt[$];
    int lat, bcyc, ndone;
    logic [31:0] res, d;
    logic [1:0] m;
    int sh;

    vt.push_back('{2'b00, 2,  32'd20,        32'd80,        3});
    vt.push_back('{2'b10, 4,  32'h8000_0000, 32'hF800_0000, 5});
    vt.push_back('{2'b01, 4,  32'h8000_0000, 32'h0800_0000, 5});
    vt.push_back('{2'b11, 1,  32'h0000_0001, 32'h8000_0000, 2});
    vt.push_back('{2'b01, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1});
    vt.push_back('{2'b10, 0,  32'h8765_4321, 32'h8765_4321, 1});
    vt.push_back('{2'b00, 31, 32'h0000_0003, 32'h8000_0000, 32});
    vt.push_back('{2'b10, 31, 32'h4000_0000, 32'h0000_0000, 32});
    vt.push_back('{2'b11, 8,  32'h1234_5678, 32'h7812_3456, 9});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0); chk("rst_res1", result1, 0);
    chk("rst_busy4", busy4, 0); chk("rst_res4", result4, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      do_op(1'b0, vt[i].m, vt[i].sh, vt[i].d, lat, bcyc, res);
      chk($sformatf("vec%0d_res", i), res, vt[i].exp_res);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_busy", i), bcyc, vt[i].exp_lat);
      chk($sformatf("vec%0d_busyoff", i), busy1, 0);
    end

    // STEP=4: shamt=31 finishes in 9 cycles
    do_op(1'b1, 2'b00, 31, 32'd1, lat, bcyc, res);
    chk("step4_res", res, 32'h8000_0000);
    chk("step4_lat", lat, 9);

    // Second start during SHIFT is ignored; exactly one done pulse
    mode = 2'b00; shamt = 5'd8; data_in = 32'd20; start1 = 1'b1;
    @(posedge clk); #1;
    mode = 2'b01; shamt = 5'd3; data_in = 32'hFFFF_0000;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done1) begin
        ndone++;
        start1 = 1'b0;
        chk("ignore_res", result1, 32'd5120);
      end
    end
    start1 = 1'b0;
    chk("ignore_ndone", ndone, 1);

    // Reset in cycle 3 of a shamt=10 request discards it
    do_op(1'b0, 2'b11, 5, 32'h0000_00F0, lat, bcyc, res);
    chk("pre_rst_res", res, 32'h8000_0007);
    mode = 2'b00; shamt = 5'd10; data_in = 32'd7; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy1, 0); chk("midrst_res", result1, 0); chk("midrst_done", done1, 0);
    reset_n = 1'b1; start1 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) ndone++;
    end
    chk("midrst_quiet", ndone, 0);
    do_op(1'b0, 2'b00, 3, 32'd5, lat, bcyc, res);
    chk("postrst_res", res, 32'd40);
    chk("postrst_lat", lat, 4);

    // Randomized against the reference model on both instances
    for (int k = 0; k < 60; k++) begin
      bit u4 = (k % 2) == 1;
      m = 2'($urandom);
      sh = int'($urandom_range(0, 31));
      d = $urandom;
      do_op(u4, m, sh, d, lat, bcyc, res);
      chk($sformatf("rnd%0d_s%0d_m%0d_sh%0d_res", k, u4 ? 4 : 1, m, sh), res, ref_shift(m, sh, d));
      chk($sformatf("rnd%0d_lat", k), lat, ref_lat(sh, u4 ? 4 : 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
